// File: rtl/serial_dmux_rx_if.sv
// Handshake bundle for the serial receive deserializer: serial beat input on one side,
// parallel word output with valid/ready and status pulses on the other.
interface serial_dmux_rx_if #(
  parameter int unsigned WIDTH = 8
);
  logic             ser_in;
  logic             ser_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             parity_err;
  logic             overrun;
  logic             busy;

  // master drives the serial link and consumes words; slave is the deserializer
  modport master (
    output ser_in, ser_valid, out_ready,
    input  out_data, out_valid, parity_err, overrun, busy
  );

  modport slave (
    input  ser_in, ser_valid, out_ready,
    output out_data, out_valid, parity_err, overrun, busy
  );
endinterface

// File: rtl/serial_dmux_rx.sv
// Bit-serial receive deserializer: start beat, WIDTH data beats LSB first, even parity beat.
// Good words land in a one-deep output slot; bad parity or a full slot drops the frame.
module serial_dmux_rx #(
  parameter int unsigned WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  serial_dmux_rx_if.slave   bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StData, StParity} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             parity_err_q, parity_err_d;
  logic             overrun_q, overrun_d;

  logic take;
  logic slot_free;

  assign take      = out_valid_q & bus.out_ready;
  assign slot_free = ~out_valid_q | bus.out_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    parity_err_d = 1'b0;
    overrun_d    = 1'b0;

    if (take) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        // a valid zero beat in idle is link filler
        if (bus.ser_valid && bus.ser_in) begin
          state_d = StData;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      StData: begin
        if (bus.ser_valid) begin
          shift_d[cnt_q] = bus.ser_in;
          if (cnt_q == LastCnt) begin
            state_d = StParity;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (bus.ser_valid) begin
          state_d = StIdle;
          if ((^shift_q) ^ bus.ser_in) begin
            parity_err_d = 1'b1;
          end else if (slot_free) begin
            // a same-cycle handshake frees the slot, so the new word replaces it
            out_data_d  = shift_q;
            out_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      shift_q      <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_serial_dmux_rx.sv
// Bench for serial_dmux_rx: directed frames then random beats, all checked against a
// bit-queue frame model that evaluates each completed frame as a whole.
module tb_serial_dmux_rx;

  localparam int unsigned WIDTH = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_dmux_rx_if #(.WIDTH(WIDTH)) bus ();

  serial_dmux_rx #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // reference model state, as seen after the most recent clock edge
  bit             m_in_frame;
  bit             m_bits[$];
  logic [WIDTH-1:0] m_data;
  bit             m_valid;
  bit             m_perr;
  bit             m_ovr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_in_frame = 1'b0;
    m_bits.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_perr  = 1'b0;
    m_ovr   = 1'b0;
  endfunction

  function automatic void model_edge(input bit sv, input bit si, input bit rdy);
    bit               free;
    int               ones;
    logic [WIDTH-1:0] w;
    free   = !m_valid || rdy;
    m_perr = 1'b0;
    m_ovr  = 1'b0;
    if (m_valid && rdy) m_valid = 1'b0;
    if (sv) begin
      if (!m_in_frame) begin
        if (si) begin
          m_in_frame = 1'b1;
          m_bits.delete();
        end
      end else begin
        m_bits.push_back(si);
        if (m_bits.size() == WIDTH + 1) begin
          ones = 0;
          w    = '0;
          for (int i = 0; i <= WIDTH; i++) begin
            if (i < WIDTH) w[i] = m_bits[i];
            ones += int'(m_bits[i]);
          end
          m_in_frame = 1'b0;
          if (ones % 2 == 1) m_perr = 1'b1;
          else if (free) begin
            m_data  = w;
            m_valid = 1'b1;
          end else m_ovr = 1'b1;
        end
      end
    end
  endfunction

  task automatic check_all();
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("out_data", 32'(bus.out_data), 32'(m_data));
    check("parity_err", 32'(bus.parity_err), 32'(m_perr));
    check("overrun", 32'(bus.overrun), 32'(m_ovr));
    check("busy", 32'(bus.busy), 32'(m_in_frame));
  endtask

  // Called at a negedge: drive one cycle of inputs, let the edge happen, check at next negedge.
  task automatic cycle(input bit sv, input bit si, input bit rdy);
    bus.ser_valid = sv;
    bus.ser_in    = si;
    bus.out_ready = rdy;
    model_edge(sv, si, rdy);
    @(negedge clk);
    check_all();
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] w, input bit flip_par, input bit stall,
                            input bit rdy, input bit rdy_last);
    logic [WIDTH+1:0] beats;
    beats = {(^w) ^ flip_par, w, 1'b1};
    for (int i = 0; i < WIDTH + 2; i++) begin
      if (stall && i != 0) cycle(1'b0, 1'($urandom), rdy);
      cycle(1'b1, beats[i], (i == WIDTH + 1) ? rdy_last : rdy);
    end
  endtask

  initial begin
    bus.ser_in    = 1'b0;
    bus.ser_valid = 1'b0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // clean frame, consumer always ready
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1);
    check("a5_valid", 32'(bus.out_valid), 32'd1);
    check("a5_data", 32'(bus.out_data), 32'hA5);
    cycle(1'b0, 1'b0, 1'b1);
    check("a5_consumed", 32'(bus.out_valid), 32'd0);

    // bad parity
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1);
    check("perr_pulse", 32'(bus.parity_err), 32'd1);
    check("perr_novalid", 32'(bus.out_valid), 32'd0);
    cycle(1'b0, 1'b0, 1'b1);
    check("perr_onecycle", 32'(bus.parity_err), 32'd0);
    check("perr_idle", 32'(bus.busy), 32'd0);

    // stalls between every beat
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
    check("3c_data", 32'(bus.out_data), 32'h3C);
    check("3c_valid", 32'(bus.out_valid), 32'd1);
    cycle(1'b0, 1'b0, 1'b1);

    // back-to-back with consumer stalled: second frame overruns
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ovr_pulse", 32'(bus.overrun), 32'd1);
    check("ovr_keep", 32'(bus.out_data), 32'h11);
    cycle(1'b0, 1'b0, 1'b1);
    check("ovr_onecycle", 32'(bus.overrun), 32'd0);
    check("ovr_consumed", 32'(bus.out_valid), 32'd0);

    // handshake on the parity beat frees the slot
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
    check("hs_data", 32'(bus.out_data), 32'h22);
    check("hs_valid", 32'(bus.out_valid), 32'd1);
    check("hs_noovr", 32'(bus.overrun), 32'd0);
    cycle(1'b0, 1'b0, 1'b1);

    // reset mid-frame
    cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    check("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    check("post_rst_data", 32'(bus.out_data), 32'h5A);
    cycle(1'b0, 1'b0, 1'b1);

    // random beats, stalls, filler and back-pressure
    for (int n = 0; n < 4000; n++) begin
      cycle(($urandom % 4) != 0, 1'($urandom), ($urandom % 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
